byte_lane_splitter: RTL and testbench
=====================================

Name: byte_lane_splitter

Overview:
- Registered 32-bit to four-byte splitter with valid/ready handshake on both sides.
- Input word A splits into byte lanes O1 (MSB) through O4 (LSB). An optional lane-reversal mode is provided.
- Sits between a 32-bit word producer and byte-oriented consumers.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- WIDTH, 32, input word width. Fixed at 32; other values are unsupported.
- LANES, 4, number of 8-bit output lanes. Fixed at 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- A  in  32  input word
- swap  in  1  lane-order select, sampled with A on each accepted transfer
- in_valid  in  1  A/swap are valid
- in_ready  out  1  splitter can accept a word; driven from a flop
- O1  out  8  lane 1
- O2  out  8  lane 2
- O3  out  8  lane 3
- O4  out  8  lane 4
- lane_zero  out  4  bit i-1 high when lane Oi == 8'h00
- out_valid  out  1  O1..O4 and lane_zero are valid
- out_ready  in  1  consumer accepts the output

Behaviour:
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Lane mapping:
  - swap=0: O1=A[31:24], O2=A[23:16], O3=A[15:8], O4=A[7:0].
  - swap=1: O1=A[7:0], O2=A[15:8], O3=A[23:16], O4=A[31:24].
- lane_zero:
  - Computed from the mapped lanes at capture time and registered with them.
- Storage:
  - Output register plus one skid register.
  - Total capacity 2 words; order is strictly FIFO.
- Latency:
  - A word accepted at edge N appears on O1..O4 with out_valid=1 after edge N, provided the output register was empty or draining at edge N.
- Throughput:
  - One word per cycle while out_ready=1.
- in_ready:
  - Registered; equals "skid register empty" after each edge.
  - When the output stalls (out_valid=1, out_ready=0) and a word is accepted, that word goes to the skid register and in_ready drops on the next cycle.
- Skid drain:
  - When the output is consumed and the skid register is full, the skid word moves to the output register on the same edge.
  - in_ready returns to 1 after that edge.
- Simultaneous accept and consume with skid empty: the new word replaces the output register directly; no bubble.
- Stability: while out_valid=1 && out_ready=0, O1..O4 and lane_zero hold stable.
- Reset (asynchronous, active-high):
  - out_valid=0, in_ready=0 while reset is asserted.
  - O1..O4=8'h00, lane_zero=4'hF, skid register empty.
  - in_ready goes to 1 on the first clk edge after reset deasserts.
- Reset mid-operation: all stored words are discarded; no partial output.
- in_valid while in_ready=0: ignored; the producer must hold the word.

Optional Feature:
- Macro SPLITTER_PARITY_EN.
- Defined:
  - Adds output port lane_parity[3:0].
  - Bit i-1 is the even-parity bit (XOR reduction) of lane Oi after mapping.
  - Registered and stalled together with the lanes.
  - Resets to 4'h0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single word:
  - Stimulus: hold reset=1; release; A=32'hFA4890A7, swap=0, in_valid=1, out_ready=1.
  - Required next cycle: O1=FA, O2=48, O3=90, O4=A7, lane_zero=0000, out_valid=1.
- Swap mode:
  - Stimulus: A=32'hFA4890A7, swap=1.
  - Required: O1=A7, O2=90, O3=48, O4=FA.
- Zero flags:
  - Stimulus: A=32'h00FF0000, swap=0.
  - Required: lane_zero=4'b1101 (O1, O3, O4 zero).
- Backpressure:
  - Stimulus: out_ready=0; stream words 11111111, 22222222, 33333333.
  - Required: the first two are accepted and in_ready drops; outputs hold 11/11/11/11.
  - Then raise out_ready: outputs 11111111, 22222222, 33333333 in order, no loss or duplication.
- Full throughput:
  - Stimulus: 16 back-to-back words with out_ready=1.
  - Required: 16 consecutive out_valid cycles, each output one cycle after its input.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges with the skid register full.
  - Required: out_valid=0 immediately (no edge needed); O1..O4=0; first word after release is a freshly accepted one.

Source files
------------

// File: rtl/byte_lane_splitter.sv
// byte_lane_splitter
//   Registered 32-bit word to four 8-bit lane splitter with valid/ready on
//   both sides. An output register plus one skid register give two words of
//   FIFO storage, one word per cycle of throughput, and a registered in_ready.
//
//   Optional feature macro: SPLITTER_PARITY_EN (adds lane_parity output).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   A            input word
//   swap         lane-order select, sampled with A on each accepted word
//   in_valid     A/swap valid
//   in_ready     splitter can accept a word (flop output)
//   O1..O4       byte lanes, O1 = most significant lane when swap=0
//   lane_zero    bit i-1 set when lane Oi is 8'h00
//   lane_parity  bit i-1 = XOR reduction of lane Oi (SPLITTER_PARITY_EN only)
//   out_valid    O1..O4 / lane_zero (/ lane_parity) valid
//   out_ready    consumer accepts the output
module byte_lane_splitter #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic             swap,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       O1,
    output logic [7:0]       O2,
    output logic [7:0]       O3,
    output logic [7:0]       O4,
    output logic [LANES-1:0] lane_zero,
`ifdef SPLITTER_PARITY_EN
    output logic [LANES-1:0] lane_parity,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int LANE_W = WIDTH / LANES;

    // Mapped view of the incoming word, packed with O1 in the top lane.
    logic [WIDTH-1:0]  map_word;
    logic [LANES-1:0]  map_zero;
    logic [LANE_W-1:0] lane;

    logic [WIDTH-1:0]  out_word;
    logic [LANES-1:0]  out_zero;
    logic [WIDTH-1:0]  skid_word;
    logic [LANES-1:0]  skid_zero;
    logic              skid_valid;
    logic              skid_valid_nxt;

`ifdef SPLITTER_PARITY_EN
    logic [LANES-1:0]  map_par;
    logic [LANES-1:0]  out_par;
    logic [LANES-1:0]  skid_par;
`endif

    logic in_xfer;
    logic out_free;

    assign in_xfer  = in_valid && in_ready;
    // Output register can take a new word: empty, or being consumed this edge.
    assign out_free = !out_valid || out_ready;

    // Lane mapping and per-lane flags, computed before capture so they are
    // registered alongside the data.
    always_comb begin
        map_word = '0;
        map_zero = '0;
        lane     = '0;
`ifdef SPLITTER_PARITY_EN
        map_par  = '0;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
            if (swap)
                map_word[WIDTH-1-i*LANE_W -: LANE_W] = A[i*LANE_W +: LANE_W];
            else
                map_word[WIDTH-1-i*LANE_W -: LANE_W] = A[WIDTH-1-i*LANE_W -: LANE_W];
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            lane        = map_word[WIDTH-1-i*LANE_W -: LANE_W];
            map_zero[i] = (lane == '0);
`ifdef SPLITTER_PARITY_EN
            map_par[i]  = ^lane;
`endif
        end
    end

    // Skid occupancy after the coming edge. When the output frees up the skid
    // word moves forward; a new word only lands in skid while the output is
    // stalled (or, defensively, if skid is being refilled as it drains).
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (out_free)
            skid_valid_nxt = skid_valid && in_xfer;
        else if (in_xfer)
            skid_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_word   <= '0;
            out_zero   <= '1;
            skid_valid <= 1'b0;
            skid_word  <= '0;
            skid_zero  <= '1;
            in_ready   <= 1'b0;
`ifdef SPLITTER_PARITY_EN
            out_par    <= '0;
            skid_par   <= '0;
`endif
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    // Older skid word goes first to keep FIFO order.
                    out_valid <= 1'b1;
                    out_word  <= skid_word;
                    out_zero  <= skid_zero;
`ifdef SPLITTER_PARITY_EN
                    out_par   <= skid_par;
`endif
                    if (in_xfer) begin
                        skid_word <= map_word;
                        skid_zero <= map_zero;
`ifdef SPLITTER_PARITY_EN
                        skid_par  <= map_par;
`endif
                    end
                end else if (in_xfer) begin
                    // Direct replacement: no bubble when accept and consume coincide.
                    out_valid <= 1'b1;
                    out_word  <= map_word;
                    out_zero  <= map_zero;
`ifdef SPLITTER_PARITY_EN
                    out_par   <= map_par;
`endif
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_word <= map_word;
                skid_zero <= map_zero;
`ifdef SPLITTER_PARITY_EN
                skid_par  <= map_par;
`endif
            end
            skid_valid <= skid_valid_nxt;
            in_ready   <= !skid_valid_nxt;
        end
    end

    assign O1        = out_word[WIDTH-1  -: 8];
    assign O2        = out_word[WIDTH-9  -: 8];
    assign O3        = out_word[WIDTH-17 -: 8];
    assign O4        = out_word[WIDTH-25 -: 8];
    assign lane_zero = out_zero;
`ifdef SPLITTER_PARITY_EN
    assign lane_parity = out_par;
`endif

endmodule

// File: tb/tb_byte_lane_splitter.sv
module tb_byte_lane_splitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0;
    logic        swap = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  O1, O2, O3, O4;
    logic [3:0]  lane_zero;
`ifdef SPLITTER_PARITY_EN
    logic [3:0]  lane_parity;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of accepted {swap, word} in FIFO order; the
    // splitter holds at most two. m_live goes high on the first edge after reset.
    logic [32:0] q[$];
    bit          m_live = 0;

    byte_lane_splitter #(.WIDTH(32), .LANES(4)) dut (
        .clk(clk), .reset(reset), .A(A), .swap(swap),
        .in_valid(in_valid), .in_ready(in_ready),
        .O1(O1), .O2(O2), .O3(O3), .O4(O4), .lane_zero(lane_zero),
`ifdef SPLITTER_PARITY_EN
        .lane_parity(lane_parity),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_lanes(input logic [32:0] e);
        logic [31:0] w;
        logic [31:0] r;
        logic [31:0] b;
        w = e[31:0];
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (e[32]) b = (w >> (8 * i)) & 32'hFF;
            else       b = (w >> (8 * (3 - i))) & 32'hFF;
            r = r | (b << (8 * (3 - i)));
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_zero(input logic [31:0] lanes);
        logic [3:0] z;
        for (int i = 0; i < 4; i++)
            z[i] = (((lanes >> (8 * (3 - i))) & 32'hFF) == 0);
        return z;
    endfunction

    function automatic logic [3:0] exp_par(input logic [31:0] lanes);
        logic [3:0] p;
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            b = (lanes >> (8 * (3 - i))) & 32'hFF;
            p[i] = 1'b0;
            for (int k = 0; k < 8; k++) p[i] = p[i] ^ b[k];
        end
        return p;
    endfunction

    function automatic logic [31:0] obs_word();
        return {O1, O2, O3, O4};
    endfunction

    // One clock: present inputs at negedge, update model, return at next negedge.
    task automatic drive(input logic v, input logic [31:0] a, input logic s,
                         input logic r, output bit acc);
        bit con;
        in_valid  = v;
        A         = a;
        swap      = s;
        out_ready = r;
        acc = v && m_live && (q.size() < 2);
        con = r && (q.size() > 0);
        if (con) void'(q.pop_front());
        if (acc) q.push_back({s, a});
        @(posedge clk);
        if (!reset) m_live = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        n_cmp++;
        if (obs_word() !== 32'h0 || lane_zero !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_data: lanes=%h zero=%b want 00000000 1111", obs_word(), lane_zero);
        end
`ifdef SPLITTER_PARITY_EN
        n_cmp++;
        if (lane_parity !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_parity: got %b want 0000", lane_parity);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_live = 0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 0 before first edge", in_ready);
        end
    endtask

    task automatic test_single();
        bit acc;
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_edge_ready: got %b want 1", in_ready);
        end
        drive(1'b1, 32'hFA4890A7, 1'b0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b1 || obs_word() !== 32'hFA4890A7 || lane_zero !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_word: v=%b lanes=%h zero=%b want 1 fa4890a7 0000",
                     out_valid, obs_word(), lane_zero);
        end
    endtask

    task automatic test_swap();
        bit acc;
        drive(1'b1, 32'hFA4890A7, 1'b1, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b1 || obs_word() !== 32'hA79048FA) begin
            n_fail++;
            $display("FAIL swap_mode: v=%b lanes=%h want 1 a79048fa", out_valid, obs_word());
        end
`ifdef SPLITTER_PARITY_EN
        n_cmp++;
        if (lane_parity !== exp_par(32'hA79048FA)) begin
            n_fail++;
            $display("FAIL swap_parity: got %b want %b", lane_parity, exp_par(32'hA79048FA));
        end
`endif
    endtask

    task automatic test_zero_flags();
        bit acc;
        drive(1'b1, 32'h00FF0000, 1'b0, 1'b1, acc);
        n_cmp++;
        if (lane_zero !== 4'b1101 || obs_word() !== 32'h00FF0000) begin
            n_fail++;
            $display("FAIL zero_flags: zero=%b lanes=%h want 1101 00ff0000", lane_zero, obs_word());
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        drive(1'b1, 32'h11111111, 1'b0, 1'b0, acc);
        n_cmp++;
        if (out_valid !== 1'b1 || obs_word() !== 32'h11111111 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: v=%b lanes=%h rdy=%b want 1 11111111 1", out_valid, obs_word(), in_ready);
        end
        drive(1'b1, 32'h22222222, 1'b0, 1'b0, acc);
        n_cmp++;
        if (in_ready !== 1'b0 || obs_word() !== 32'h11111111) begin
            n_fail++;
            $display("FAIL bp_skid_full: rdy=%b lanes=%h want 0 11111111", in_ready, obs_word());
        end
        drive(1'b1, 32'h33333333, 1'b0, 1'b0, acc);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs_word() !== 32'h11111111 || lane_zero !== 4'h0) begin
            n_fail++;
            $display("FAIL bp_hold: rdy=%b v=%b lanes=%h want 0 1 11111111", in_ready, out_valid, obs_word());
        end
        drive(1'b1, 32'h33333333, 1'b0, 1'b1, acc);
        n_cmp++;
        if (obs_word() !== 32'h22222222 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain2: lanes=%h rdy=%b want 22222222 1", obs_word(), in_ready);
        end
        drive(1'b1, 32'h33333333, 1'b0, 1'b1, acc);
        n_cmp++;
        if (obs_word() !== 32'h33333333 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain3: lanes=%h v=%b want 33333333 1", obs_word(), out_valid);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [31:0] w;
        int run;
        run = 0;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            drive(1'b1, w, 1'b0, 1'b1, acc);
            n_cmp++;
            if (out_valid !== 1'b1 || obs_word() !== w) begin
                n_fail++;
                $display("FAIL b2b_word%0d: v=%b lanes=%h want 1 %h", i, out_valid, obs_word(), w);
            end else begin
                run++;
            end
        end
        n_cmp++;
        if (run != 16) begin
            n_fail++;
            $display("FAIL b2b_run: consecutive=%0d want 16", run);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
    endtask

    task automatic test_random();
        bit acc;
        logic [31:0] pw;
        logic ps, pv, r;
        logic [31:0] e;
        pv = 0;
        pw = $urandom;
        ps = $urandom_range(0, 1);
        for (int i = 0; i < 300; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pw = $urandom;
                if ($urandom_range(0, 4) == 0) pw = pw & 32'h00FF00FF;
                ps = $urandom_range(0, 1);
            end
            r = ($urandom_range(0, 2) != 0);
            drive(pv, pw, ps, r, acc);
            if (acc) pv = 0;
            n_cmp++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags@%0d: v=%b rdy=%b want %b %b", i, out_valid, in_ready,
                         q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                e = exp_lanes(q[0]);
                n_cmp++;
                if (obs_word() !== e || lane_zero !== exp_zero(e)) begin
                    n_fail++;
                    $display("FAIL rand_data@%0d: lanes=%h zero=%b want %h %b", i, obs_word(),
                             lane_zero, e, exp_zero(e));
                end
`ifdef SPLITTER_PARITY_EN
                n_cmp++;
                if (lane_parity !== exp_par(e)) begin
                    n_fail++;
                    $display("FAIL rand_parity@%0d: got %b want %b", i, lane_parity, exp_par(e));
                end
`endif
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
    endtask

    task automatic test_async_reset();
        bit acc;
        drive(1'b1, 32'hAAAA5555, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h12345678, 1'b0, 1'b0, acc);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_setup: rdy=%b v=%b want 0 1", in_ready, out_valid);
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || obs_word() !== 32'h0 || lane_zero !== 4'hF || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: v=%b lanes=%h zero=%b rdy=%b want 0 00000000 1111 0",
                     out_valid, obs_word(), lane_zero, in_ready);
        end
        q.delete();
        m_live = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'hC0FFEE01, 1'b0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b0 || acc) begin
            n_fail++;
            $display("FAIL arst_no_stale: v=%b lanes=%h want 0", out_valid, obs_word());
        end
        drive(1'b1, 32'hC0FFEE01, 1'b0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b1 || obs_word() !== 32'hC0FFEE01) begin
            n_fail++;
            $display("FAIL arst_fresh: v=%b lanes=%h want 1 c0ffee01", out_valid, obs_word());
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_single: v=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_swap();
        test_zero_flags();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
